// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified memory between the fetch and load/store ports.
// Data wins ties, bounded by a fetch anti-starvation streak; a watchdog aborts hung accesses.
module unified_mem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int DATA_MAX = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ready,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          err,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   localparam int SW = $clog2(DATA_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t        state_q, state_d;
   logic          owner_d_q, owner_d_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          i_ready_q, i_ready_d;
   logic          d_ready_q, d_ready_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          err_q, err_d;

   logic          grant_data;
   logic          finish;
   logic          timed_out;

   always_comb begin
      state_d     = state_q;
      owner_d_d   = owner_d_q;
      streak_d    = streak_q;
      tmo_d       = tmo_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      err_d       = 1'b0;
      grant_data  = 1'b0;
      finish      = 1'b0;
      timed_out   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               // Fetch only overrides data once data has won DATA_MAX times in a row.
               grant_data = d_req && !(i_req && (streak_q == SW'(DATA_MAX)));
               owner_d_d  = grant_data;
               mem_req_d  = 1'b1;
               tmo_d      = '0;
               state_d    = S_BUSY;
               if (grant_data) begin
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  if (!i_req)
                     streak_d = '0;
                  else if (streak_q != SW'(DATA_MAX))
                     streak_d = SW'(streak_q + 1'b1);
               end else begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = '0;
                  streak_d    = '0;
               end
            end
         end
         S_BUSY: begin
            if (mem_ack) begin
               finish = 1'b1;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               finish    = 1'b1;
               timed_out = 1'b1;
            end else begin
               tmo_d = TW'(tmo_q + 1'b1);
            end
            if (finish) begin
               state_d   = S_RESP;
               mem_req_d = 1'b0;
               tmo_d     = '0;
               err_d     = timed_out;
               if (owner_d_q) begin
                  d_ready_d = 1'b1;
                  if (timed_out)
                     d_rdata_d = '0;
                  else if (!mem_we_q)
                     d_rdata_d = mem_rdata;
               end else begin
                  i_ready_d = 1'b1;
                  i_rdata_d = timed_out ? '0 : mem_rdata;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         owner_d_q   <= 1'b0;
         streak_q    <= '0;
         tmo_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_d_q   <= owner_d_d;
         streak_q    <= streak_d;
         tmo_q       <= tmo_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_ready   = i_ready_q;
   assign d_ready   = d_ready_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign err       = err_q;

   // The core must freeze in the same cycle a request is pending, so this stays combinational.
   assign stall = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: table-driven single transactions, a response scoreboard,
// and hand-written reset, arbitration, timeout and mid-access reset sequences.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [31:0] i_rdata, d_rdata;
   logic        i_ready, d_ready, err, stall;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;
   int ack_lat  = 1;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_cyc;
   } vec_t;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t        sb[$];
   vec_t        vecs[10];
   logic [31:0] mem_arr [0:255];

   unified_mem_arbiter #(.AW(32), .DW(32), .DATA_MAX(4), .TIMEOUT(255)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready), .err(err), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Memory model: acks on the ack_lat-th cycle of an access; ack_lat=0 never acks.
   initial begin
      int mcnt;
      mcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      for (int k = 0; k < 256; k++) mem_arr[k] = 32'h0;
      mem_arr[8'h00] = 32'h2002_0005;
      mem_arr[8'h04] = 32'hA5A5_0004;
      mem_arr[8'h10] = 32'hDEAD_BEEF;
      mem_arr[8'h20] = 32'h1111_2020;
      mem_arr[8'h24] = 32'h2222_2424;
      forever begin
         @(negedge clk);
         if (mem_req === 1'b1) begin
            mcnt++;
            mem_rdata = mem_arr[mem_addr[7:0]];
            mem_ack = (ack_lat != 0) && (mcnt == ack_lat);
            if (mem_ack && mem_we) mem_arr[mem_addr[7:0]] = mem_wdata;
         end else begin
            mcnt = 0;
            mem_ack = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
         end
      end
   end

   // Response monitor: every ready pulse must match the oldest expected response.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (i_ready === 1'b1 || d_ready === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_ready", {30'h0, i_ready, d_ready}, 32'h0);
            end else begin
               e = sb.pop_front();
               check("rsp_port", {31'h0, d_ready}, {31'h0, e.is_d});
               check("rsp_rdata", d_ready ? d_rdata : i_rdata, e.rdata);
               check("rsp_err", {31'h0, err}, {31'h0, e.err});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic do_txn(input vec_t v);
      int cyc, busy_cyc, bad_mem;
      logic done;
      ack_lat = v.lat;
      sb.push_back('{v.is_d, v.exp_rdata, v.exp_err});
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      cyc = 0; busy_cyc = 0; bad_mem = 0; done = 1'b0;
      while (!done && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) check("stall_wait", {31'h0, stall}, 32'h1);
         if (mem_req) begin
            busy_cyc++;
            if (mem_we !== v.we || mem_addr !== v.addr || mem_wdata !== (v.we ? v.wdata : 32'h0))
               bad_mem++;
         end
         done = v.is_d ? d_ready : i_ready;
      end
      check("stall_at_ready", {31'h0, stall}, 32'h0);
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      check("latency", cyc, v.exp_cyc);
      check("mem_req_cycles", busy_cyc, (v.lat == 0) ? 255 : v.lat);
      check("mem_stable", bad_mem, 0);
      @(posedge clk); #1;
      check("idle_after", {28'h0, mem_req, i_ready, d_ready, err}, 32'h0);
   endtask

   initial begin
      logic grant_exp [10];
      logic prev;
      int n, cyc;

      vecs[0] = '{1'b0, 1'b0, 32'h00, 32'h0,        1, 32'h2002_0005, 1'b0, 2};
      vecs[1] = '{1'b1, 1'b1, 32'h54, 32'h7,        3, 32'hDEAD_BEEF, 1'b0, 4};
      vecs[2] = '{1'b1, 1'b0, 32'h54, 32'h0,        2, 32'h0000_0007, 1'b0, 3};
      vecs[3] = '{1'b0, 1'b0, 32'h04, 32'h0,        5, 32'hA5A5_0004, 1'b0, 6};
      vecs[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        1, 32'hDEAD_BEEF, 1'b0, 2};
      vecs[5] = '{1'b1, 1'b1, 32'h10, 32'h1234_5678, 1, 32'hDEAD_BEEF, 1'b0, 2};
      vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        1, 32'h1234_5678, 1'b0, 2};
      vecs[7] = '{1'b1, 1'b0, 32'hC8, 32'h0,        0, 32'h0,         1'b1, 256};
      vecs[8] = '{1'b1, 1'b0, 32'h54, 32'h0,        1, 32'h0000_0007, 1'b0, 2};
      vecs[9] = '{1'b0, 1'b0, 32'hC8, 32'h0,        0, 32'h0,         1'b1, 256};
      grant_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      reset = 1'b0;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = 32'h0;
      ack_lat = 1;

      // Reset held two cycles with a data request pending.
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1;
         check("rst_ctrl", {27'h0, mem_req, mem_we, i_ready, d_ready, err}, 32'h0);
         check("rst_addr", mem_addr, 32'h0);
         check("rst_data", i_rdata | d_rdata | mem_wdata, 32'h0);
      end
      sb.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
      reset = 1'b1;
      @(posedge clk); #1;
      check("first_grant_req", {31'h0, mem_req}, 32'h1);
      check("first_grant_addr", mem_addr, 32'h10);
      cyc = 0;
      while (!d_ready && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      check("first_ready_seen", {31'h0, d_ready}, 32'h1);
      d_req = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 10; v++) do_txn(vecs[v]);

      // Both ports held continuously: fetch gets every fifth grant.
      ack_lat = 1;
      for (int g = 0; g < 10; g++)
         sb.push_back('{grant_exp[g], grant_exp[g] ? 32'h2222_2424 : 32'h1111_2020, 1'b0});
      i_req = 1'b1; i_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
      n = 0; cyc = 0; prev = mem_req;
      while (n < 10 && cyc < 100) begin
         @(posedge clk); #1; cyc++;
         if (mem_req && !prev) begin
            check($sformatf("grant%0d", n), mem_addr, grant_exp[n] ? 32'h24 : 32'h20);
            check("stall_both", {31'h0, stall}, 32'h1);
            n++;
            if (n == 10) d_req = 1'b0;
         end
         prev = mem_req;
      end
      check("grant_count", n, 10);
      cyc = 0;
      while (!i_ready && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      check("arb_last_ready", {31'h0, i_ready}, 32'h1);
      i_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset during the second BUSY cycle of a fetch abandons it.
      ack_lat = 0;
      i_req = 1'b1; i_addr = 32'h40;
      @(posedge clk); #1;
      check("abort_grant", {31'h0, mem_req}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort_req_drop", {31'h0, mem_req}, 32'h0);
      check("abort_no_ready", {31'h0, i_ready}, 32'h0);
      i_req = 1'b0;
      reset = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("abort_quiet", {30'h0, mem_req, i_ready}, 32'h0);
      end
      do_txn(vecs[0]);

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the MIPS fetch port and the load/store port.
- Registered request/ready handshake on each requester side; request/ack handshake on the memory side.
- Data port has priority, with an anti-starvation limit for fetch and a watchdog timeout on memory acks.
- Sits between the core and the memory inside top. The core stalls while its requester is waiting.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- DATA_MAX, 4, maximum consecutive data grants while fetch is waiting.
- TIMEOUT, 255, BUSY cycles without mem_ack before the transaction aborts with an error.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ready.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched word; valid when i_ready=1.
- i_ready  out  1  one-cycle fetch completion pulse.
- d_req  in  1  load/store request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid when d_ready=1.
- d_ready  out  1  one-cycle data completion pulse.
- err  out  1  pulses with ready when the transaction timed out.
- stall  out  1  combinational: (i_req&~i_ready)|(d_req&~d_ready).
- mem_req  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, sampled while mem_req=1.

Behaviour:
- Reset: reset=0 at a rising edge puts the FSM in IDLE and clears all of the following:
  - mem_req, mem_we, mem_addr, mem_wdata
  - i_ready, d_ready, i_rdata, d_rdata
  - err, streak counter, timeout counter
- Reset mid-transaction abandons the access: mem_req drops the next cycle and no ready pulse is issued.
- All outputs except stall are registered.
- FSM states are IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch the owner, drive mem_req=1 and drive mem_we/mem_addr/mem_wdata from the granted port (mem_we=0, mem_wdata=0 for fetch), then go to BUSY.
  - Grant priority:
    - Only one requester: grant it.
    - Both requesting: grant data, unless streak==DATA_MAX, in which case grant fetch.
  - Streak counter:
    - Increments on a data grant while i_req=1.
    - Clears on a fetch grant, or on a data grant with i_req=0.
    - Saturates at DATA_MAX.
- BUSY:
  - Hold mem_* stable.
  - Timeout counter increments each cycle mem_ack=0.
  - mem_ack=1: go to RESP and drop mem_req. Owner's ready goes to 1. For a load or fetch, owner's rdata = mem_rdata; for a store, d_rdata keeps its old value.
  - Counter reaches TIMEOUT: go to RESP, drop mem_req, owner's ready=1, owner's rdata=0, err=1.
- RESP:
  - Ready (and err) are high for exactly this cycle.
  - Next state is IDLE; ready and err clear. No grant decision is made in RESP.
  - Requesters deassert or change their request on the edge that ends RESP.
- Latency: request first sampled at edge T gives mem_req from T+1. Ack sampled at edge T+1 gives ready from T+2. Minimum request-to-ready is 2 cycles; back-to-back grants are every 3 cycles minimum.
- rdata holds its value after ready until the next completion for that port.
- A request change while BUSY is ignored; the latched values are used.
- mem_ack outside BUSY is ignored.

Test Plan:
- Reset=0 for 2 cycles with d_req=1, then released: all outputs 0 during reset; first grant appears one cycle after release.
- Fetch i_addr=0x0, memory acks after 1 cycle with 0x20020005: i_ready pulses 2 cycles after i_req, i_rdata=0x20020005, mem_we=0 throughout.
- Store d_addr=84, d_wdata=7, d_we=1, ack after 3 cycles: mem_addr=84, mem_wdata=7, mem_we=1 held for 3 cycles; d_ready pulses once; err=0.
- i_req and d_req both held continuously, with DATA_MAX=4 and 1-cycle acks: grant order D,D,D,D,I,D,D,D,D,I; stall=1 while each port waits.
- No ack for 255 BUSY cycles on a load: d_ready=1, err=1, d_rdata=0 in the same cycle; FSM back in IDLE next cycle; the next request is serviced normally.
- reset=0 asserted in the second BUSY cycle of a fetch: mem_req=0 next cycle, no i_ready pulse; after release a fresh i_req completes normally.
